// File: rtl/palette_index_encoder.sv
// Nearest-colour encoder: maps a 12-bit RGB pixel to the index of the closest
// entry in a loadable 16-entry palette, scanning one entry per clock.
module palette_index_encoder #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int CH_W        = 4,
  parameter int DIST_W      = 6
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                pal_we,
  input  logic [IDX_W-1:0]    pal_waddr,
  input  logic [3*CH_W-1:0]   pal_wdata,
  output logic                pal_busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_red,
  input  logic [CH_W-1:0]     in_green,
  input  logic [CH_W-1:0]     in_blue,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_index,
  output logic [DIST_W-1:0]   out_dist,
  output logic                out_exact,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE and it
  // holds its payload steady until out_ready is seen.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state;
  logic [3*CH_W-1:0]   r_pal [NUM_ENTRIES];
  logic [CH_W-1:0]     r_red, r_green, r_blue;
  logic [IDX_W-1:0]    r_scan_idx, r_best_idx;
  logic [DIST_W-1:0]   r_best_dist;
  logic                r_in_ready, r_pal_busy, r_out_valid, r_out_exact;
  logic [IDX_W-1:0]    r_out_index;
  logic [DIST_W-1:0]   r_out_dist;

  logic [3*CH_W-1:0]   w_entry;
  logic [CH_W-1:0]     w_pr, w_pg, w_pb;
  logic [CH_W-1:0]     w_dr, w_dg, w_db;
  logic [DIST_W-1:0]   w_dist, w_new_dist;
  logic [IDX_W-1:0]    w_new_idx;
  logic                w_better, w_last;

  assign w_entry = r_pal[r_scan_idx];
  assign w_pr    = w_entry[3*CH_W-1:2*CH_W];
  assign w_pg    = w_entry[2*CH_W-1:CH_W];
  assign w_pb    = w_entry[CH_W-1:0];

  assign w_dr = (r_red   >= w_pr) ? (r_red   - w_pr) : (w_pr - r_red);
  assign w_dg = (r_green >= w_pg) ? (r_green - w_pg) : (w_pg - r_green);
  assign w_db = (r_blue  >= w_pb) ? (r_blue  - w_pb) : (w_pb - r_blue);

  assign w_dist = {{(DIST_W-CH_W){1'b0}}, w_dr}
                + {{(DIST_W-CH_W){1'b0}}, w_dg}
                + {{(DIST_W-CH_W){1'b0}}, w_db};

  // Strict compare so ties keep the earlier (lower) index.
  assign w_better   = (w_dist < r_best_dist);
  assign w_new_dist = w_better ? w_dist : r_best_dist;
  assign w_new_idx  = w_better ? r_scan_idx : r_best_idx;
  assign w_last     = (r_scan_idx == IDX_W'(NUM_ENTRIES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_pal[i] <= '0;
    end else if (pal_we && (r_state == S_IDLE)) begin
      r_pal[pal_waddr] <= pal_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_scan_idx  <= '0;
      r_best_idx  <= '0;
      r_best_dist <= '1;
      r_in_ready  <= 1'b1;
      r_pal_busy  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_dist  <= '0;
      r_out_exact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_red       <= in_red;
            r_green     <= in_green;
            r_blue      <= in_blue;
            r_scan_idx  <= '0;
            r_best_idx  <= '0;
            r_best_dist <= '1;
            r_in_ready  <= 1'b0;
            r_pal_busy  <= 1'b1;
            r_state     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          r_best_dist <= w_new_dist;
          r_best_idx  <= w_new_idx;
          if ((w_dist == '0) || w_last) begin
            r_out_index <= w_new_idx;
            r_out_dist  <= w_new_dist;
            r_out_exact <= (w_new_dist == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_pal_busy  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_pal_busy  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign pal_busy  = r_pal_busy;
  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_dist  = r_out_dist;
  assign out_exact = r_out_exact;
  assign dbg_state = r_state;

endmodule
